// File: rtl/vga_pattern_engine.sv
// Animated multi-mode VGA test-pattern generator: registered RGB plus delayed sync.
// Animation state steps on vsync rising edges detected in the pixel clock domain.
module vga_pattern_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int COLOR_BITS  = 2,
    parameter int CNT_WIDTH   = 10,
    parameter int SPEED_WIDTH = 4,
    parameter int BOX_SIZE    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   video_active,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic [1:0]             mode,
    input  logic [SPEED_WIDTH-1:0] speed,
    input  logic                   pause,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic [COLOR_BITS-1:0]  r,
    output logic [COLOR_BITS-1:0]  g,
    output logic [COLOR_BITS-1:0]  b,
    output logic                   frame_tick,
    output logic [CNT_WIDTH-1:0]   frame_count
);
    localparam logic [9:0]  BX_MAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  BY_MAX = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
    localparam logic [COLOR_BITS-1:0] ONES = {COLOR_BITS{1'b1}};

    typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

    logic                   vsync_d_q;
    logic [1:0]             mode_q, mode_d;
    logic [SPEED_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_WIDTH-1:0]   counter_q, counter_d;
    logic [9:0]             bx_q, bx_d, by_q, by_d;
    dir_e                   dx_q, dx_d, dy_q, dy_d;
    logic [COLOR_BITS-1:0]  r_q, g_q, b_q, r_d, g_d, b_d;
    logic                   hsync_q, vsync_q, tick_q;
    logic                   fe, step;

    logic [9:0] cnt10, xor_v, bar_s;
    logic       chk_c, in_box;

    always_comb begin
        fe        = vsync_in & ~vsync_d_q;
        step      = fe & ~pause & (div_cnt_q == speed);
        mode_d    = fe ? mode : mode_q;
        div_cnt_d = div_cnt_q;
        if (fe && !pause) begin
            // a speed lowered below the running count restarts the prescaler
            if (div_cnt_q >= speed) div_cnt_d = '0;
            else                    div_cnt_d = div_cnt_q + SPEED_WIDTH'(1);
        end
        counter_d = step ? counter_q + CNT_WIDTH'(1) : counter_q;
        bx_d = bx_q;
        dx_d = dx_q;
        by_d = by_q;
        dy_d = dy_q;
        if (step) begin
            if (dx_q == DIR_POS) begin
                if (bx_q == BX_MAX) begin bx_d = bx_q - 10'd1; dx_d = DIR_NEG; end
                else                      bx_d = bx_q + 10'd1;
            end else begin
                if (bx_q == 10'd0)  begin bx_d = 10'd1;        dx_d = DIR_POS; end
                else                      bx_d = bx_q - 10'd1;
            end
            if (dy_q == DIR_POS) begin
                if (by_q == BY_MAX) begin by_d = by_q - 10'd1; dy_d = DIR_NEG; end
                else                      by_d = by_q + 10'd1;
            end else begin
                if (by_q == 10'd0)  begin by_d = 10'd1;        dy_d = DIR_POS; end
                else                      by_d = by_q - 10'd1;
            end
        end
    end

    always_comb begin
        cnt10  = 10'(counter_q);
        bar_s  = pix_x + cnt10;
        xor_v  = bar_s ^ pix_y;
        chk_c  = pix_x[5] ^ pix_y[5] ^ counter_q[0];
        in_box = ({1'b0, pix_x} >= {1'b0, bx_q}) && ({1'b0, pix_x} < ({1'b0, bx_q} + BOX_W)) &&
                 ({1'b0, pix_y} >= {1'b0, by_q}) && ({1'b0, pix_y} < ({1'b0, by_q} + BOX_W));
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (video_active) begin
            case (mode_q)
                2'd0: begin
                    r_d = xor_v[4 +: COLOR_BITS];
                    g_d = xor_v[5 +: COLOR_BITS];
                    b_d = xor_v[6 +: COLOR_BITS];
                end
                2'd1: begin
                    r_d = bar_s[7] ? ONES : '0;
                    g_d = bar_s[8] ? ONES : '0;
                    b_d = bar_s[9] ? ONES : '0;
                end
                2'd2: begin
                    r_d = chk_c ? ONES : '0;
                    g_d = chk_c ? ONES : '0;
                    b_d = chk_c ? ONES : '0;
                end
                default: begin
                    r_d = in_box ? ONES : '0;
                    g_d = in_box ? ONES : '0;
                    b_d = in_box ? ONES : COLOR_BITS'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d_q <= 1'b0;
            mode_q    <= 2'd0;
            div_cnt_q <= '0;
            counter_q <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            dx_q      <= DIR_POS;
            dy_q      <= DIR_POS;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vsync_d_q <= vsync_in;
            mode_q    <= mode_d;
            div_cnt_q <= div_cnt_d;
            counter_q <= counter_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hsync_q   <= hsync_in;
            vsync_q   <= vsync_in;
            tick_q    <= step;
        end
    end

    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign frame_tick  = tick_q;
    assign frame_count = counter_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Directed testbench for vga_pattern_engine with default 640x480, 2-bit colour parameters.
module tb_vga_pattern_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync_in, vsync_in, video_active, pause;
    logic [9:0] pix_x, pix_y;
    logic [1:0] mode;
    logic [3:0] speed;
    logic       hsync_out, vsync_out, frame_tick;
    logic [1:0] r, g, b;
    logic [9:0] frame_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_pattern_engine dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y), .mode(mode),
        .speed(speed), .pause(pause), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .r(r), .g(g), .b(b), .frame_tick(frame_tick), .frame_count(frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one vsync pulse: t1 = tick in the cycle after the edge, t2 = tick one cycle later
    task automatic vpulse(output logic t1, output logic t2);
        vsync_in = 1'b1;
        @(negedge clk);
        t1 = frame_tick;
        vsync_in = 1'b0;
        @(negedge clk);
        t2 = frame_tick;
        @(negedge clk);
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic va, input logic [5:0] exp);
        pix_x = x;
        pix_y = y;
        video_active = va;
        @(negedge clk);
        chk(tag, 32'({r, g, b}), 32'(exp));
    endtask

    initial begin
        logic       t1, t2;
        logic [7:0] tp;
        logic [1:0] hv;
        int         nt, nt2;

        rst_n = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; video_active = 1'b0; pause = 1'b0;
        pix_x = '0; pix_y = '0; mode = '0; speed = '0;
        repeat (3) begin
            hsync_in     = 1'($urandom_range(0, 1));
            vsync_in     = 1'($urandom_range(0, 1));
            video_active = 1'($urandom_range(0, 1));
            pause        = 1'($urandom_range(0, 1));
            pix_x        = 10'($urandom_range(0, 1023));
            pix_y        = 10'($urandom_range(0, 1023));
            mode         = 2'($urandom_range(0, 3));
            speed        = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_hs", 32'(hsync_out), 32'd0);
        chk("rst_vs", 32'(vsync_out), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_cnt", 32'(frame_count), 32'd0);

        hsync_in = 1'b0; vsync_in = 1'b0; video_active = 1'b0; pause = 1'b0;
        pix_x = '0; pix_y = '0; mode = 2'd0; speed = 4'd0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cnt", 32'(frame_count), 32'd0);
        hsync_in = 1'b1;
        #1;
        chk("hs_nodelay", 32'(hsync_out), 32'd0);
        @(negedge clk);
        chk("hs_delay1", 32'(hsync_out), 32'd1);
        hsync_in = 1'b0;
        @(negedge clk);
        chk("hs_fall", 32'(hsync_out), 32'd0);

        // speed 0: every frame steps
        nt = 0; nt2 = 0;
        for (int i = 0; i < 5; i++) begin
            vpulse(t1, t2);
            nt += int'(t1);
            nt2 += int'(t2);
        end
        chk("spd0_ticks", 32'(nt), 32'd5);
        chk("spd0_cnt", 32'(frame_count), 32'd5);

        // speed 3: steps on pulses 4 and 8
        speed = 4'd3;
        tp = '0;
        for (int i = 0; i < 8; i++) begin
            vpulse(t1, t2);
            tp[i] = t1;
            nt2 += int'(t2);
        end
        chk("spd3_pattern", 32'(tp), 32'h88);
        chk("spd3_cnt", 32'(frame_count), 32'd7);

        // lowering speed below the running prescaler count restarts it
        speed = 4'd5;
        tp = '0;
        for (int i = 0; i < 3; i++) begin
            vpulse(t1, t2);
            tp[i] = t1;
            nt2 += int'(t2);
        end
        speed = 4'd1;
        for (int i = 3; i < 6; i++) begin
            vpulse(t1, t2);
            tp[i] = t1;
            nt2 += int'(t2);
        end
        chk("spd_lower_pattern", 32'(tp), 32'h20);
        chk("spd_lower_cnt", 32'(frame_count), 32'd8);
        chk("tick_single_clk", 32'(nt2), 32'd0);

        // pause: state frozen, mode still latched
        pause = 1'b1;
        pix("xor_c8", 10'd0, 10'd48, 1'b1, 6'h34);
        mode = 2'd2;
        pix("xor_hold", 10'd0, 10'd48, 1'b1, 6'h34);
        nt = 0;
        for (int i = 0; i < 4; i++) begin
            vpulse(t1, t2);
            nt += int'(t1) + int'(t2);
        end
        chk("pause_ticks", 32'(nt), 32'd0);
        chk("pause_cnt", 32'(frame_count), 32'd8);
        pix("chk_00", 10'd0, 10'd0, 1'b1, 6'h00);
        pix("chk_32_0", 10'd32, 10'd0, 1'b1, 6'h3F);
        pix("chk_32_32", 10'd32, 10'd32, 1'b1, 6'h00);

        mode = 2'd3;
        vpulse(t1, t2);
        pix("box_tl", 10'd8, 10'd8, 1'b1, 6'h3F);
        pix("box_left_out", 10'd7, 10'd8, 1'b1, 6'h01);
        pix("box_top_out", 10'd8, 10'd7, 1'b1, 6'h01);
        pix("box_br", 10'd39, 10'd39, 1'b1, 6'h3F);
        pix("box_right_out", 10'd40, 10'd8, 1'b1, 6'h01);
        pix("box_bot_out", 10'd8, 10'd40, 1'b1, 6'h01);

        // mode latch at frame boundary
        pause = 1'b0;
        speed = 4'd0;
        mode  = 2'd0;
        vpulse(t1, t2);
        chk("unpause_tick", 32'(t1), 32'd1);
        pix("xor_c9", 10'd0, 10'd100, 1'b1, 6'h2D);
        mode = 2'd1;
        pix("xor_midframe", 10'd0, 10'd100, 1'b1, 6'h2D);
        vpulse(t1, t2);
        chk("cnt10", 32'(frame_count), 32'd10);
        pix("bar_130", 10'd130, 10'd0, 1'b1, 6'h30);
        pix("bar_300", 10'd300, 10'd0, 1'b1, 6'h0C);
        pix("bar_1000", 10'd1000, 10'd0, 1'b1, 6'h3F);
        pix("bar_wrap", 10'd1020, 10'd0, 1'b1, 6'h00);
        pix("bar_edge_in", 10'd118, 10'd0, 1'b1, 6'h30);
        pix("bar_edge_out", 10'd117, 10'd0, 1'b1, 6'h00);

        // blanking in every mode
        pause = 1'b1;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            vpulse(t1, t2);
            pix($sformatf("blank_m%0d", m), 10'd130, 10'd0, 1'b0, 6'h00);
        end

        // reset mid-run, release with vsync already high
        pause = 1'b0; speed = 4'd0; mode = 2'd3; video_active = 1'b0;
        vsync_in = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst2_cnt", 32'(frame_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_high_tick", 32'(frame_tick), 32'd1);
        chk("rel_high_cnt", 32'(frame_count), 32'd1);
        vsync_in = 1'b0;
        @(negedge clk);
        @(negedge clk);

        nt = 0;
        for (int i = 0; i < 607; i++) begin
            vpulse(t1, t2);
            nt += int'(t1);
        end
        chk("bounce_ticks", 32'(nt), 32'd607);
        chk("bounce_cnt", 32'(frame_count), 32'd608);
        pix("bx608_in", 10'd608, 10'd288, 1'b1, 6'h3F);
        pix("bx608_last_col", 10'd639, 10'd288, 1'b1, 6'h3F);
        pix("bx608_row0", 10'd639, 10'd0, 1'b1, 6'h01);
        pix("bx608_left_out", 10'd607, 10'd288, 1'b1, 6'h01);
        pix("by288_bot_in", 10'd608, 10'd319, 1'b1, 6'h3F);
        pix("by288_bot_out", 10'd608, 10'd320, 1'b1, 6'h01);
        vpulse(t1, t2);
        pix("bx607_in", 10'd607, 10'd287, 1'b1, 6'h3F);
        pix("bx607_right_out", 10'd639, 10'd287, 1'b1, 6'h01);
        pix("bx607_right_in", 10'd638, 10'd287, 1'b1, 6'h3F);

        for (int i = 0; i < 415; i++) vpulse(t1, t2);
        chk("cnt_wrap", 32'(frame_count), 32'd0);

        // sync alignment
        for (int i = 0; i < 8; i++) begin
            hv = 2'($urandom_range(0, 3));
            hsync_in = hv[1];
            vsync_in = hv[0];
            @(negedge clk);
            chk("sync_align", 32'({hsync_out, vsync_out}), 32'(hv));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
